// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and width helpers for the FIFO push arbiter
// Purpose: FSM state type, default geometry, and width helpers for count/pointer.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUSH  = 2'd1,
    STALL = 2'd2
  } arb_state_t;

  localparam int unsigned DEF_BITS  = 32;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_N_REQ = 4;

  // count must represent 0..depth inclusive, hence depth+1 codes
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // producer pointer; at least one bit even for degenerate sizes
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CNT_W = cnt_w(DEF_DEPTH);
  localparam int unsigned PTR_W = ptr_w(DEF_N_REQ);

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// rtl/fifo_push_arbiter_if.sv - producer/FIFO/consumer signal bundle for the push arbiter
// Purpose: groups every non-clock signal of the arbiter.
// master: arbiter side (drives ack, fifo_din, fifo_push, fifo_pop, count, err_*).
// slave : environment side (drives req, req_din, fifo_full, fifo_pndng, cons_pop).
interface fifo_push_arbiter_if #(
  parameter int unsigned bits  = 32,
  parameter int unsigned depth = 16,
  parameter int unsigned n_req = 4
) ();
  import fifo_arb_pkg::*;

  localparam int unsigned CW = cnt_w(depth);

  logic [n_req-1:0]           req;
  logic [n_req-1:0][bits-1:0] req_din;
  logic [n_req-1:0]           ack;
  logic [bits-1:0]            fifo_din;
  logic                       fifo_push;
  logic                       fifo_full;
  logic                       fifo_pndng;
  logic                       fifo_pop;
  logic                       cons_pop;
  logic [CW-1:0]              count;
  logic                       err_ovf;
  logic                       err_udf;

  modport master (
    input  req, req_din, fifo_full, fifo_pndng, cons_pop,
    output ack, fifo_din, fifo_push, fifo_pop, count, err_ovf, err_udf
  );

  modport slave (
    output req, req_din, fifo_full, fifo_pndng, cons_pop,
    input  ack, fifo_din, fifo_push, fifo_pop, count, err_ovf, err_udf
  );
endinterface

// File: rtl/fifo_push_arbiter_rr_arbiter.sv
// rtl/fifo_push_arbiter_rr_arbiter.sv - combinational round-robin pick
// Purpose: one-hot grant of the first eligible producer after `last`.
// Ports: eligible (in, n_req), last (in, pointer), grant (out, one-hot), valid (out).
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned n_req = 4
) (
  input  logic [n_req-1:0]        eligible,
  input  logic [ptr_w(n_req)-1:0] last,
  output logic [n_req-1:0]        grant,
  output logic                    valid
);

  localparam int unsigned PW = ptr_w(n_req);

  logic          found;
  logic [PW-1:0] idx;

  // Walk last+1 .. last+n_req (mod n_req); the first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= int'(n_req); k++) begin
      idx = PW'((int'(last) + k) % int'(n_req));
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid = |eligible;

endmodule

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin push arbiter in front of a flop FIFO
// Purpose: shares the FIFO push port among n_req producers, tracks occupancy so
// it never pushes into a full FIFO, gates consumer pops, and latches errors.
// Ports: clk, rst (async active-low), bus (fifo_push_arbiter_if.master).
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned bits  = 32,
  parameter int unsigned depth = 16,
  parameter int unsigned n_req = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_push_arbiter_if.master bus
);

  localparam int unsigned CW = cnt_w(depth);
  localparam int unsigned PW = ptr_w(n_req);

  arb_state_t       state_q, state_d;
  logic [PW-1:0]    last_q, last_d;
  logic [n_req-1:0] ack_q, ack_d;
  logic             push_q;
  logic [bits-1:0]  din_q, din_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, udf_q;

  logic [n_req-1:0] eligible;
  logic [n_req-1:0] grant;
  logic             valid;
  logic             room;
  logic             grant_en;
  logic             pop;
  logic [PW-1:0]    win_idx;

  // The producer being acked this cycle still shows req; mask it so it is not
  // granted a second time for the same word.
  assign eligible = bus.req & ~ack_q;

  rr_arbiter #(.n_req(n_req)) u_rr (
    .eligible (eligible),
    .last     (last_q),
    .grant    (grant),
    .valid    (valid)
  );

  assign pop      = bus.cons_pop & bus.fifo_pndng;
  // Uses the registered count, so a pop at full only frees room next cycle.
  assign room     = (count_q < CW'(depth));
  assign grant_en = valid & room;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < int'(n_req); i++) begin
      if (grant[i]) win_idx = PW'(i);
    end
  end

  always_comb begin
    state_d = IDLE;
    if (valid) state_d = room ? PUSH : STALL;

    ack_d  = grant_en ? grant : '0;
    last_d = grant_en ? win_idx : last_q;
    din_d  = grant_en ? bus.req_din[win_idx] : din_q;

    count_d = count_q;
    case ({grant_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = (count_q == '0) ? count_q : count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= PW'(n_req - 1);
      ack_q   <= '0;
      push_q  <= 1'b0;
      din_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      push_q  <= grant_en;
      din_q   <= din_d;
      count_q <= count_d;
      ovf_q   <= ovf_q | (push_q & bus.fifo_full);
      udf_q   <= udf_q | (bus.cons_pop & ~bus.fifo_pndng);
    end
  end

  assign bus.ack       = ack_q;
  assign bus.fifo_push = push_q;
  assign bus.fifo_din  = din_q;
  assign bus.fifo_pop  = pop;
  assign bus.count     = count_q;
  assign bus.err_ovf   = ovf_q;
  assign bus.err_udf   = udf_q;

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin controller that shares the push side of one flop-based FIFO (depth `depth`, width `bits`) among `n_req` producers and gates the consumer's pop against the FIFO's pending flag. The block tracks occupancy internally, so it never issues a push into a full FIFO. It also flags protocol errors. It sits between the producer agents and the FIFO instance, and owns the FIFO's `push`, `Din` and `pop` inputs.

## Interface
- `bits`, 32: data width; must match the FIFO.
- `depth`, 16: FIFO depth; the occupancy limit.
- `n_req`, 4: number of producers, 2..16.

Clock and reset come first.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset; 0 forces reset state immediately.

Producer ports:
- `req` in `n_req`: per-producer push request; held with `req_din` until `ack`.
- `req_din` in `n_req`×`bits`: per-producer data.
- `ack` out `n_req`: one-hot, one-cycle accept pulse, coincident with `fifo_push`.

FIFO ports:
- `fifo_din` out `bits`: registered data to the FIFO `Din`.
- `fifo_push` out 1: registered one-cycle push strobe.
- `fifo_full` in 1: FIFO full flag.
- `fifo_pndng` in 1: FIFO non-empty flag.
- `fifo_pop` out 1: combinational, `cons_pop & fifo_pndng`.

Consumer and status ports:
- `cons_pop` in 1: consumer pop request.
- `count` out `$clog2(depth+1)`: committed occupancy.
- `err_ovf` out 1: sticky; set when `fifo_push & fifo_full`.
- `err_udf` out 1: sticky; set when `cons_pop & !fifo_pndng`.

## Operation
- States: IDLE (no push issued), PUSH (`fifo_push` high this cycle), STALL (requests present, `count == depth`).
- Eligible set: `req` masked by the bit currently asserted on `ack`. This prevents double grant while a producer drops `req`.
- Transitions from any state:
  - eligible ≠ 0 and `count < depth` → PUSH, granting a winner.
  - eligible ≠ 0 and `count == depth` → STALL.
  - otherwise → IDLE.
- Arbitration: search starts at `last+1` mod `n_req` and picks the first eligible. On a grant, `last` ← winner.
- On a grant edge:
  - `fifo_din` ← `req_din[winner]`.
  - `fifo_push` ← 1 and `ack[winner]` ← 1 for exactly one cycle.
- `count` update:
  - +1 on a grant edge and −1 on an edge where `fifo_pop` = 1.
  - Both on the same edge: unchanged.
  - Never exceeds `depth`; never decrements below 0. `fifo_pop` requires `fifo_pndng`.
- A pop in the same cycle as `count == depth` does not enable a grant that cycle. The grant occurs next cycle.
- Error flags clear only on reset. Errors do not alter arbitration.
- `fifo_din` holds its last value when not pushing.

## Timing
- Reset values:
  - state IDLE, `last` = `n_req-1` (producer 0 wins first).
  - `fifo_push` 0, `fifo_din` 0, `ack` 0, `count` 0, `err_ovf` 0, `err_udf` 0.
- Latency: `req` high at edge N → `fifo_push`/`ack` high in cycle N+1. Producers may change data at the edge ending the `ack` cycle.
- Throughput: one push per cycle with two or more producers and room available. A single producer gets every other cycle because of the ack masking.
- `fifo_pop` has zero latency, combinational from `cons_pop`/`fifo_pndng`.
- Reset mid-push: `fifo_push`/`ack` drop asynchronously. The in-flight datum is considered lost, and producers re-request.

## Structure
- Package `fifo_arb_pkg`:
  - state enum typedef `arb_state_t` {IDLE, PUSH, STALL}.
  - width localparams for `count` and the pointer.
- Sub-module `rr_arbiter`: combinational; inputs `eligible` and `last`; outputs one-hot `grant` and `valid`.
- The top level holds the FSM, `count`, output registers and error flags.

## Test plan
All scenarios use `depth`=16, `n_req`=4, `bits`=32.
1. Reset release with `req`=4'b0000 → all outputs 0, state IDLE, `count`=0 for 10 cycles.
2. `req`=4'b1111 held with data 0xA0..0xA3 → grant order 0,1,2,3,0…. Each `ack` coincides with `fifo_push` and matching `fifo_din`. No producer is acked twice in a row.
3. Single producer 2, 20 words, no pops → 16 pushes at alternating cycles, `count`=16. The FSM then holds STALL with no further `fifo_push`.
4. From `count`=16, pulse `cons_pop` for one cycle with `fifo_pndng`=1 → `fifo_pop`=1, `count`=15. One grant follows next cycle, and `count` returns to 16.
5. Simultaneous grant and pop at `count`=8 → `count` stays 8. `cons_pop` with `fifo_pndng`=0 → `fifo_pop`=0 and `err_udf`=1, held until reset.
6. Assert `rst`=0 asynchronously during a `fifo_push` cycle → `fifo_push`/`ack` fall before the next edge and `count`=0. Arbitration restarts at producer 0.
